// File: rtl/alu_dot_sequencer.sv
// Coprocessor that sequences the shared ALU to compute a packed int8 dot product
// over two word vectors read from a 1-cycle-latency memory.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; parameters captured on accept
// S_RD_A  | read A[idx]
// S_RD_B  | read B[idx]; A[idx] arrives and is latched
// S_MAC   | B[idx] arrives; 4-lane signed MAC of A and B into prod
// S_ACC   | acc += prod; advance idx or finish
// S_RELU  | clamp negative final sum to zero
// S_DONE  | one-cycle done pulse
module alu_dot_sequencer #(
  parameter int LEN_W       = 16,
  parameter int ADDR_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      base_a,
  input  logic [31:0]      base_b,
  input  logic [LEN_W-1:0] len,
  input  logic             relu_en,
  output logic             mem_ren,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  output logic [4:0]       alu_ctl,
  output logic             alu_sign,
  input  logic [31:0]      alu_out,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
);

  localparam logic [4:0] OP_MAC  = 5'b11011;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_RELU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_MAC, S_ACC, S_RELU, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      base_a_q, base_b_q;
  logic [LEN_W-1:0] len_q;
  logic             relu_q;
  logic [31:0]      acc, prod, a_reg;
  logic [LEN_W-1:0] idx;
  logic [31:0]      offset;
  logic             last_elem;

  assign offset    = 32'(idx) * 32'(ADDR_STRIDE);
  assign last_elem = (idx == len_q - LEN_W'(1));
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    mem_ren  = 1'b0;
    mem_addr = '0;
    alu_in1  = '0;
    alu_in2  = '0;
    alu_ctl  = '0;
    alu_sign = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (len == '0) ? S_DONE : S_RD_A;
      end
      S_RD_A: begin
        mem_ren  = 1'b1;
        mem_addr = base_a_q + offset;
        state_d  = S_RD_B;
      end
      S_RD_B: begin
        mem_ren  = 1'b1;
        mem_addr = base_b_q + offset;
        state_d  = S_MAC;
      end
      S_MAC: begin
        alu_in1 = a_reg;
        alu_in2 = mem_rdata;
        alu_ctl = OP_MAC;
        state_d = S_ACC;
      end
      S_ACC: begin
        alu_in1 = acc;
        alu_in2 = prod;
        alu_ctl = OP_ADD;
        if (last_elem) state_d = relu_q ? S_RELU : S_DONE;
        else           state_d = S_RD_A;
      end
      S_RELU: begin
        alu_in2 = acc;
        alu_ctl = OP_RELU;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // abort freezes every datapath register so result keeps its previous value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      base_a_q <= '0;
      base_b_q <= '0;
      len_q    <= '0;
      relu_q   <= 1'b0;
      acc      <= '0;
      prod     <= '0;
      a_reg    <= '0;
      idx      <= '0;
      result   <= '0;
    end else begin
      state_q <= state_d;
      if (!abort) begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              base_a_q <= base_a;
              base_b_q <= base_b;
              len_q    <= len;
              relu_q   <= relu_en;
              acc      <= '0;
              idx      <= '0;
              if (len == '0) result <= '0;
            end
          end
          S_RD_B: a_reg <= mem_rdata;
          S_MAC:  prod  <= alu_out;
          S_ACC: begin
            acc <= alu_out;
            idx <= idx + LEN_W'(1);
            if (last_elem && !relu_q) result <= alu_out;
          end
          S_RELU: result <= alu_out;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/alu_dot_sequencer.md
# alu_dot_sequencer

Multi-cycle controller that computes a packed int8 dot product by sequencing the shared ALU through its 4-lane MAC, add and ReLU operations. Operands are fetched from a single-ported word memory with 1-cycle read latency. The block sits beside the execute stage as a coprocessor. While busy it owns the ALU operand/control inputs; the pipeline stall/mux that hands the ALU over is external. Started by a one-cycle command, it reports a 32-bit result with a done pulse.

## Interface
- `LEN_W`, 16: width of the element-count field and of the internal index.
- `ADDR_STRIDE`, 4: byte increment between consecutive operand words.
- `clk`  in  1  : clock, rising edge.
- `reset_n`  in  1  : asynchronous, active-low reset.
- `start`  in  1  : command strobe; sampled only in IDLE.
- `abort`  in  1  : synchronous cancel; any state returns to IDLE on the next edge.
- `base_a`  in  32  : byte address of vector A; captured on accepted start.
- `base_b`  in  32  : byte address of vector B; captured on accepted start.
- `len`  in  LEN_W  : number of 32-bit words per vector; captured on accepted start.
- `relu_en`  in  1  : apply ReLU to the final sum; captured on accepted start.
- `mem_ren`  out  1  : memory read enable.
- `mem_addr`  out  32  : memory read address.
- `mem_rdata`  in  32  : read data, valid the cycle after `mem_ren`.
- `alu_in1`  out  32  : ALU operand 1.
- `alu_in2`  out  32  : ALU operand 2.
- `alu_ctl`  out  5  : ALU opcode.
- `alu_sign`  out  1  : ALU sign select.
- `alu_out`  in  32  : combinational ALU result.
- `busy`  out  1  : high whenever state is not IDLE.
- `done`  out  1  : one-cycle pulse; `result` is valid from this cycle on.
- `result`  out  32  : final dot product; holds until the next accepted start.

## Operation
States: IDLE, RD_A, RD_B, MAC, ACC, RELU, DONE. Internal registers: `acc`, `prod`, `a_reg`, `idx`.
- **IDLE.** `start=1` captures the parameters and clears `acc` and `idx`.
  - If `len==0`, go to DONE.
  - Otherwise go to RD_A.
- **RD_A.** `mem_ren=1`, `mem_addr = base_a + ADDR_STRIDE*idx`. Go to RD_B.
- **RD_B.** `mem_ren=1`, `mem_addr = base_b + ADDR_STRIDE*idx`. Capture `a_reg <= mem_rdata`. Go to MAC.
- **MAC.** Drive `alu_in1=a_reg`, `alu_in2=mem_rdata`, `alu_ctl=5'b11011`, `alu_sign=0`. Capture `prod <= alu_out`. Go to ACC.
  - The ALU returns the sum of the four signed byte-lane products.
- **ACC.** Drive `alu_in1=acc`, `alu_in2=prod`, `alu_ctl=5'b00010`. Update `acc <= alu_out` and `idx <= idx+1`.
  - If `idx==len-1`: go to RELU when `relu_en`, else to DONE, with `result <= alu_out`.
  - Otherwise go to RD_A.
- **RELU.** Drive `alu_in1=0`, `alu_in2=acc`, `alu_ctl=5'b11100`. Capture `result <= alu_out` (negative becomes 0). Go to DONE.
- **DONE.** `done=1`. Go to IDLE.
- **Outputs outside their driving state.** `alu_*` = 0 (opcode 00000), `mem_ren=0`, `mem_addr=0`.
- **Arithmetic width.** All arithmetic is 32-bit modulo 2^32: the accumulator wraps silently and addresses wrap past 0xFFFFFFFC.
- **len==0.** `result=0`, with or without `relu_en`; no memory reads occur.
- **start outside IDLE.** Ignored, including in DONE.
- **abort.** Wins over all transitions. `result` keeps its previous value and no `done` is produced.
- **abort and start together in IDLE.** `abort` wins; the block stays IDLE.

## Timing
- Reset values: state=IDLE, `busy=0`, `done=0`, `result=0`, `mem_ren=0`, `mem_addr=0`, all `alu_*=0`, internal registers 0.
- Asserting `reset_n` low mid-operation forces the reset values immediately, asynchronously.
- Edge numbering: E0 is the edge that accepts `start`. `busy` rises in the cycle after E0.
- Each element takes 4 edges.
- `done` is high in the cycle following edge E(4·len + r), where r=1 if `relu_en` and len>0, else 0.
  - With `len==0`, `done` is high in the cycle after E0.
- `busy` falls in the cycle after `done`. A new `start` can be accepted on the edge that ends that cycle.
- The memory must return `mem_rdata` exactly one cycle after the address; there is no wait state.

## Test plan
- **Basic dot product.** len=1, A=0x01020304, B=0x01010101, relu_en=0 -> `result=10`; `done` 5 cycles after the start edge.
- **Signed, two words.** len=2, A={0x01020304, 0xFFFFFFFF}, B={0x01010101, 0x01010101} -> `result=6`. Check the `mem_addr` sequence is base_a, base_b, base_a+4, base_b+4.
- **ReLU.** A=0xFFFFFFFF, B=0x01010101, len=1:
  - relu_en=1 -> `result=0`, `done` at cycle 6.
  - relu_en=0 -> `result=0xFFFFFFFC`.
- **Zero length.** len=0, relu_en=1 -> `done` in the cycle after E0, `result=0`, `mem_ren` never asserted.
- **Abort.** Assert `abort` in MAC of element 0 -> IDLE next cycle, no `done`, `result` unchanged. A `start` during the run is ignored.
- **Reset and wrap.**
  - `reset_n` low mid-ACC -> all outputs 0 at once.
  - `base_a=0xFFFFFFFC`, len=2 -> second A address is 0x00000000.
